decimal_counter_core: RTL and testbench
=======================================

DECIMAL_COUNTER_CORE -- requirements
Module: decimal_counter

Interface
REQ-001 The block SHALL have no parameters; widths and count sequence are fixed.
REQ-002 CP1_n  input  1  the single clock; all state SHALL update only on its falling edge.
REQ-003 R0_1, R0_2  input  1 each  reset pair; reset is synchronous and active-high, asserted when R0_1 AND R0_2 = 1.
REQ-004 R9_1, R9_2  input  1 each  synchronous set-to-9 pair, asserted when R9_1 AND R9_2 = 1.
REQ-005 CP2_n  input  1  synchronous count enable for the divide-by-5 section, sampled on CP1_n falling edge, not a clock.
REQ-006 Qa  output  1  divide-by-2 section output, registered.
REQ-007 Qb, Qc, Qd  output  1 each  divide-by-5 section outputs, registered; Qb is the LSB, Qd the MSB.
REQ-008 The block SHALL contain exactly one clock domain (CP1_n) and no asynchronous set or clear paths.

Function
REQ-009 On each CP1_n falling edge with neither R0 nor R9 asserted, Qa SHALL toggle.
REQ-010 On each CP1_n falling edge with neither R0 nor R9 asserted and CP2_n = 1, {Qd,Qc,Qb} SHALL advance 000->001->010->011->100->000.
REQ-011 With CP2_n = 0 and no reset or set asserted, {Qd,Qc,Qb} SHALL hold.
REQ-012 Unused states 101, 110 and 111 SHALL go to 000 on the next enabled advance.
REQ-013 Unused states SHALL be cleared by R0 and overwritten by R9 like any other state.
REQ-014 With CP2_n tied externally to Qa, the outputs {Qd,Qc,Qb,Qa} SHALL count BCD 0,1,...,9,0 with one step per CP1_n falling edge.
REQ-015 In that BCD mode there SHALL be no intermediate or skipped values.
REQ-016 Both sections SHALL update on the same clock edge; there SHALL be no ripple delay between sections.
REQ-017 Each section SHALL also operate standalone: Qa as divide-by-2, and Qb..Qd as divide-by-5 under the CP2_n enable.
REQ-018 Outputs SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.

Reset
REQ-019 When R0 is asserted and R9 is not, the next CP1_n falling edge SHALL load Qd,Qc,Qb,Qa = 0000.
REQ-020 When R9 is asserted, the next CP1_n falling edge SHALL load Qd,Qc,Qb,Qa = 1001 (decimal 9).
REQ-021 R9 SHALL take priority over R0 when both are asserted.
REQ-022 R9 SHALL take priority over R0 when R0 is unknown.
REQ-023 R0 and R9 SHALL take priority over counting and over CP2_n.
REQ-024 Output values before the first reset or set edge SHALL be undefined.
REQ-025 Counting SHALL resume from the reset or set value on the first falling edge after R0 and R9 are both deasserted.
REQ-026 Asserting R0 in the middle of a count SHALL clear all outputs on the next edge, with no partial update.

Verification
REQ-027 Set-to-9 check: R9_1 = R9_2 = 1 with R0 unknown, then one CP1_n falling edge -> Qd..Qa = 1001.
REQ-028 Reset-over-count check: R0_1 = R0_2 = 1 with R9_2 = 0 and R9_1 toggling over several edges -> outputs stay 0000.
REQ-029 BCD count check: CP2_n = Qa, then release R0 -> count 1,2,...,9,0,1 on successive falling edges, with 9->0 on the 10th edge.
REQ-030 Mid-count reset check: R0 reasserted at count 5 -> 0000 on the next edge; release R0 -> 1 on the following edge.
REQ-031 Priority check: R0 and R9 both asserted -> 1001.
REQ-032 Standalone divide-by-5 check: CP2_n = 1 constant -> Qb..Qd cycle with period 5 edges; CP2_n = 0 -> hold; forced state 110 -> 000 on the next enabled edge.

Source files
------------

// File: rtl/decimal_counter_core.sv
// Decade counter core: a divide-by-2 section (Qa) and a divide-by-5 section
// (Qd,Qc,Qb) clocked together on the falling edge of CP1_n. CP2_n is a
// synchronous enable for the divide-by-5 section. Tying CP2_n to Qa outside
// the block turns {Qd,Qc,Qb,Qa} into a BCD counter that steps once per edge.
// R9 (set-to-9) outranks R0 (clear), and both outrank counting. Both are
// sampled on the clock edge only, so there is no asynchronous path.
module decimal_counter_core (
  input  logic CP1_n,
  input  logic R0_1,
  input  logic R0_2,
  input  logic R9_1,
  input  logic R9_2,
  input  logic CP2_n,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd
);

  logic       r0_req;
  logic       r9_req;
  logic       qa_q;
  logic       qa_d;
  logic [2:0] cnt5_q;   // {Qd,Qc,Qb}
  logic [2:0] cnt5_d;

  assign r0_req = R0_1 & R0_2;
  assign r9_req = R9_1 & R9_2;

  // Free-running next count for both sections; reset and set are applied in the register.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    qa_d   = ~qa_q;
    cnt5_d = cnt5_q;
    if (CP2_n) begin
      case (cnt5_q)
        3'd0:    cnt5_d = 3'd1;
        3'd1:    cnt5_d = 3'd2;
        3'd2:    cnt5_d = 3'd3;
        3'd3:    cnt5_d = 3'd4;
        default: cnt5_d = 3'd0;  // 4 wraps; unused 5..7 recover to 0
      endcase
    end
  end

  // State update on CP1_n falling edge; set-to-9 wins over clear, both win over counting.
  always_ff @(negedge CP1_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // R9 is tested first so that an unknown R0 cannot disturb a set-to-9.
    if (r9_req) begin
      qa_q   <= 1'b1;
      cnt5_q <= 3'b100;
    end else if (r0_req) begin
      qa_q   <= 1'b0;
      cnt5_q <= 3'b000;
    end else begin
      qa_q   <= qa_d;
      cnt5_q <= cnt5_d;
    end
  end

  // Outputs come straight from the flops.
  assign Qa = qa_q;
  assign Qb = cnt5_q[0];
  assign Qc = cnt5_q[1];
  assign Qd = cnt5_q[2];

endmodule

// File: tb/tb_decimal_counter_core.sv
// Scoreboard bench for decimal_counter_core. Stimulus is applied just after
// the rising edge of CP1_n; the expected value after the following falling
// edge is queued; a monitor samples the outputs on the next rising edge.
module tb_decimal_counter_core;

  logic CP1_n = 1'b1;
  always #5 CP1_n = ~CP1_n;

  logic R0_1 = 1'b0, R0_2 = 1'b0, R9_1 = 1'b0, R9_2 = 1'b0;
  logic cp2_drv = 1'b0;
  logic bcd_mode = 1'b0;
  logic CP2_n;
  logic Qa, Qb, Qc, Qd;

  // BCD mode wires CP2_n to Qa outside the block.
  assign CP2_n = bcd_mode ? Qa : cp2_drv;

  decimal_counter_core dut (
    .CP1_n (CP1_n),
    .R0_1  (R0_1),
    .R0_2  (R0_2),
    .R9_1  (R9_1),
    .R9_2  (R9_2),
    .CP2_n (CP2_n),
    .Qa    (Qa),
    .Qb    (Qb),
    .Qc    (Qc),
    .Qd    (Qd)
  );

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: Qa as a bit, the divide-by-5 section as an integer 0..7.
  int m_qa = 0;
  int m_d5 = 0;
  bit m_known = 1'b0;

  // Drive inputs, advance the model by one falling edge and queue the expectation.
  task automatic step(input logic r01, input logic r02, input logic r91, input logic r92,
                      input logic cp2, input logic bcd, input string tag, input int dec_exp);
    logic r0;
    logic r9;
    int   en;
    R0_1 = r01; R0_2 = r02; R9_1 = r91; R9_2 = r92;
    cp2_drv  = cp2;
    bcd_mode = bcd;
    r0 = r01 & r02;
    r9 = r91 & r92;
    en = (bcd === 1'b1) ? m_qa : ((cp2 === 1'b1) ? 1 : 0);
    if (r9 === 1'b1) begin
      m_qa = 1; m_d5 = 4; m_known = 1'b1;
    end else if (r0 === 1'b1) begin
      m_qa = 0; m_d5 = 0; m_known = 1'b1;
    end else begin
      m_qa = 1 - m_qa;
      if (en != 0) m_d5 = (m_d5 < 4) ? m_d5 + 1 : 0;
    end
    if (m_known) begin
      exp_t e;
      e.exp = (dec_exp >= 0) ? 4'(dec_exp) : 4'(m_d5 * 2 + m_qa);
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic apply(input logic r01, input logic r02, input logic r91, input logic r92,
                       input logic cp2, input logic bcd, input string tag, input int dec_exp);
    @(posedge CP1_n);
    #1;
    step(r01, r02, r91, r92, cp2, bcd, tag, dec_exp);
  endtask

  // Place the divide-by-5 section in an arbitrary (possibly unused) state, then apply one vector.
  task automatic forced_apply(input logic [2:0] st, input logic r01, input logic r02,
                              input logic r91, input logic r92, input logic cp2, input string tag);
    @(posedge CP1_n);
    #1;
    force dut.cnt5_q = st;
    #1;
    release dut.cnt5_q;
    m_d5 = int'(st);
    step(r01, r02, r91, r92, cp2, 1'b0, tag, -1);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    forever begin
      @(posedge CP1_n);
      if (sb_q.size() > 0) begin
        exp_t e;
        logic [3:0] got;
        e   = sb_q.pop_front();
        got = {Qd, Qc, Qb, Qa};
        n_vec++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %b expected %b (t=%0t)", e.tag, got, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Set-to-9 from an undefined start with R0 unknown.
    apply(1'bx, 1'bx, 1'b1, 1'b1, 1'b1, 1'b0, "set9_r0x", -1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "set9_hold", -1);

    // Clear holds over counting while R9_1 toggles and R9_2 stays low.
    for (int i = 0; i < 5; i++)
      apply(1'b1, 1'b1, logic'(i % 2), 1'b0, 1'b1, 1'b0, "reset_over_count", 0);

    // BCD mode: 1..9,0,1,2 with 9->0 on the 10th edge.
    for (int k = 1; k <= 12; k++)
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bcd_count", k % 10);

    // Continue to 5, clear mid-count, then resume at 1.
    for (int k = 3; k <= 5; k++)
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bcd_to5", k);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "mid_reset", 0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "resume", 1);

    // Both asserted: set-to-9 wins.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "priority", 9);

    // Standalone divide-by-5 with constant enable, then hold.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "div5_clear", 0);
    for (int i = 0; i < 10; i++)
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "div5_run", -1);
    for (int i = 0; i < 4; i++)
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div5_hold", -1);

    // Unused states: recovery, hold, clear and set.
    forced_apply(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "unused110_adv");
    forced_apply(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "unused111_adv");
    forced_apply(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "unused101_hold");
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "unused101_adv", -1);
    forced_apply(3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "unused111_set9");
    forced_apply(3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "unused101_clear");

    // Randomized traffic, alternating blocks of standalone and BCD operation.
    for (int b = 0; b < 12; b++) begin
      logic bcd;
      bcd = logic'($urandom_range(0, 1));
      for (int i = 0; i < 25; i++)
        apply(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 1)), bcd, "random", -1);
    end

    repeat (2) @(posedge CP1_n);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
